cdc_token_fifo_tx: RTL and testbench
====================================

// Module: cdc_token_fifo_tx
// PURPOSE
//  Write (source) half of the token-ring dual-clock FIFO that carries each AXI channel between the SoC and cluster domains.
//  Accepts valid/ready beats in its own clock domain and stores them in a local slot buffer.
//  Publishes a Johnson-coded writetoken_o; takes back the receiver's Johnson-coded readpointer.
//  data_async_o is the slot the receiver currently points at. One instance per channel (AW, AR, W master side; R, B slave side).
// PARAMETERS
//  DATA_WIDTH    32  payload bits per beat (packed channel fields)
//  BUFFER_DEPTH  8   slots; legal >= 2; token/pointer width = BUFFER_DEPTH
// PORTS
//  clk_i                 in   1             source-domain clock
//  rstn_i                in   1             asynchronous reset, active low
//  valid_i               in   1             beat offered
//  data_i                in   DATA_WIDTH    beat payload
//  ready_o               out  1             beat accepted when valid_i & ready_o at posedge
//  writetoken_o          out  BUFFER_DEPTH  Johnson write counter, registered, to receiver
//  readpointer_async_i   in   BUFFER_DEPTH  Johnson read counter from receiver domain (asynchronous)
//  data_async_o          out  DATA_WIDTH    buffer[slot addressed by readpointer_async_i], combinational
// BEHAVIOUR
//  Reset values:
//   - wt_q (drives writetoken_o) = 0; rp_sync = 0; buffer = 0; en_q = 0; ready_o = 0.
//  Johnson code, N = BUFFER_DEPTH:
//   - next(x) = {x[N-2:0], ~x[N-1]}; 2N states; exactly one bit changes per step (CDC safe per bit).
//   - idx(x) = x[N-1] ? N - popcount(x) : popcount(x).
//  Reader pointer sync:
//   - Each bit of readpointer_async_i passes through a 2-flop synchronizer -> rp_sync.
//   - No other logic samples readpointer_async_i, except the combinational data_async_o mux.
//  Status (from registered values only):
//   - empty = (wt_q == rp_sync); full = (wt_q == ~rp_sync).
//  Handshake:
//   - ready_o = en_q & ~full.
//   - en_q goes 1 on the first posedge after reset release, so ready_o is 0 during reset and for that first cycle.
//   - ready_o must not depend combinationally on valid_i.
//  Push (valid_i & ready_o at posedge):
//   - buffer[idx(wt_q)] <= data_i; wt_q <= next(wt_q).
//   - Zero-cycle acceptance; writetoken_o changes the same edge.
//  Occupied-slot stability:
//   - A slot written is never rewritten until rp_sync shows it freed.
//   - data_async_o is therefore stable while the receiver reads it.
//  Free latency:
//   - A receiver pointer step reaches rp_sync at the 2nd source posedge after it settles.
//   - ready_o rises in that same cycle, if full was the only blocker.
//  Wrap-around: inherent in the 2N-state code; no separate wrap bit.
//  Boundary conditions:
//   - full & valid_i: hold, no write, wt_q unchanged; data_i may change freely (not captured).
//   - Pointer step and push in the same cycle: the push is evaluated against the old rp_sync.
//   - Reset mid-operation: all queued beats discarded, wt_q = 0. Receiver must be reset in the same reset window.
//  Illegal readpointer codes (non-Johnson) are not produced by the receiver; assertion only, no recovery.
// STRUCTURE
//  Package cdc_token_pkg:
//   - function johnson_next(logic [N-1:0]); function johnson_idx(logic [N-1:0]) -> $clog2(N) bits.
//   - Shared with the receiver half.
//  Sub-module cdc_2ff_sync (1-bit, async active-low reset to 0), instantiated BUFFER_DEPTH times.
//  Buffer: flop array with per-slot write enable; read mux indexed by johnson_idx(readpointer_async_i).
// TESTING (N=8, DATA_WIDTH=32)
//  1. rstn_i=0 -> writetoken_o=8'h00, ready_o=0; release -> ready_o=0 first posedge, 1 from second.
//  2. rp held 8'h00; push 8'hA0..8'hA7 back-to-back.
//     -> writetoken_o 01,03,07,0F,1F,3F,7F,FF; ready_o=0 after 8th; 9th beat stalls, wt stays FF.
//  3. From full: rp=8'h00 -> data_async_o=A0; rp=8'h01 -> data_async_o=A1 immediately.
//     -> ready_o=1 at 2nd posedge after the change; next push writes slot 0, wt=8'hFE.
//  4. Reference receiver model draining at random rate in an unrelated clock, 1000 beats.
//     -> in-order, lossless, no duplicates; wt passes all 16 codes.
//  5. Full, rp steps in the same cycle valid_i=1 -> beat not accepted that cycle; accepted exactly when rp_sync updates.
//  6. 3 beats queued, assert rstn_i mid-cycle -> writetoken_o=0, ready_o=0 asynchronously; after release FIFO empty.

Source files
------------

// File: rtl/cdc_token_pkg.sv
// Johnson-code helpers shared by both halves of the token-ring dual-clock FIFO.
// Functions take the live width n so one definition serves every BUFFER_DEPTH up to MAX_DEPTH.
package cdc_token_pkg;

    localparam int unsigned MAX_DEPTH = 64;
    localparam int unsigned MAX_IDX_W = 7;

    typedef logic [MAX_DEPTH-1:0] token_t;
    typedef logic [MAX_IDX_W-1:0] slot_idx_t;

    // One Johnson step over the low n bits: shift left, feed back the inverted MSB.
    function automatic token_t johnson_next(input token_t x, input int unsigned n);
        token_t r;
        r = '0;
        for (int unsigned i = 1; i < MAX_DEPTH; i++) begin
            if (i < n) begin
                r[i] = x[i-1];
            end
            if (i == n - 1) begin
                r[0] = ~x[i];
            end
        end
        return r;
    endfunction

    function automatic slot_idx_t johnson_idx(input token_t x, input int unsigned n);
        slot_idx_t ones;
        logic      msb;
        ones = '0;
        msb  = 1'b0;
        for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
            if (i < n) begin
                ones = ones + slot_idx_t'(x[i]);
                if (i == n - 1) begin
                    msb = x[i];
                end
            end
        end
        return msb ? slot_idx_t'(n) - ones : ones;
    endfunction

    // A legal Johnson code has at most one boundary between runs of equal bits.
    function automatic logic johnson_valid(input token_t x, input int unsigned n);
        int unsigned edges;
        edges = 0;
        for (int unsigned i = 0; i < MAX_DEPTH - 1; i++) begin
            if ((i + 1 < n) && (x[i] != x[i+1])) begin
                edges = edges + 1;
            end
        end
        return edges <= 1;
    endfunction

endpackage

// File: rtl/cdc_2ff_sync.sv
// Single-bit two-flop synchronizer, asynchronous active-low reset to 0.
module cdc_2ff_sync (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state uses non-blocking assignments so both stages sample the pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/cdc_token_fifo_tx.sv
// Source half of the token-ring dual-clock FIFO: accepts beats, publishes a Johnson write token,
// and exposes the slot the receiver's (asynchronous) Johnson read pointer addresses.
module cdc_token_fifo_tx
    import cdc_token_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BUFFER_DEPTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    valid_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic                    ready_o,
    output logic [BUFFER_DEPTH-1:0] writetoken_o,
    input  logic [BUFFER_DEPTH-1:0] readpointer_async_i,
    output logic [DATA_WIDTH-1:0]   data_async_o
);

    localparam int unsigned IDX_W = $clog2(BUFFER_DEPTH);

    logic [BUFFER_DEPTH-1:0] wt_q;
    logic [BUFFER_DEPTH-1:0] wt_d;
    logic [BUFFER_DEPTH-1:0] rp_sync;
    logic                    en_q;
    logic [DATA_WIDTH-1:0]   buf_q [BUFFER_DEPTH];

    logic             full;
    logic             empty;
    logic             push;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    token_t    wt_next_wide;
    slot_idx_t wr_idx_wide;
    slot_idx_t rd_idx_wide;
    logic      unused_wide;

    for (genvar g = 0; g < BUFFER_DEPTH; g++) begin : gen_rp_sync
        cdc_2ff_sync u_rp_sync (
            .clk_i  (clk_i),
            .rstn_i (rstn_i),
            .d_i    (readpointer_async_i[g]),
            .q_o    (rp_sync[g])
        );
    end

    always_comb begin
        wt_next_wide = johnson_next(token_t'(wt_q), BUFFER_DEPTH);
        wr_idx_wide  = johnson_idx(token_t'(wt_q), BUFFER_DEPTH);
        rd_idx_wide  = johnson_idx(token_t'(readpointer_async_i), BUFFER_DEPTH);
    end

    assign wt_d        = wt_next_wide[BUFFER_DEPTH-1:0];
    assign wr_idx      = wr_idx_wide[IDX_W-1:0];
    assign rd_idx      = rd_idx_wide[IDX_W-1:0];
    assign unused_wide = ^{wt_next_wide, wr_idx_wide, rd_idx_wide};

    // Status from registered values only, so ready_o never sees valid_i or the raw pointer.
    assign empty        = (wt_q == rp_sync);
    assign full         = (wt_q == ~rp_sync);
    assign ready_o      = en_q & ~full;
    assign push         = valid_i & ready_o;
    assign writetoken_o = wt_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wt_q <= '0;
            en_q <= 1'b0;
        end else begin
            en_q <= 1'b1;
            if (push) begin
                wt_q <= wt_d;
            end
        end
    end

    // NOTE: the slot array is reset so data_async_o is defined (zero) before any beat lands.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < BUFFER_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < BUFFER_DEPTH; i++) begin
                if (push && (wr_idx == IDX_W'(i))) begin
                    buf_q[i] <= data_i;
                end
            end
        end
    end

    // NOTE: data_async_o gets a default before the mux so no latch is inferred.
    always_comb begin
        data_async_o = '0;
        for (int i = 0; i < BUFFER_DEPTH; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                data_async_o = buf_q[i];
            end
        end
    end

    a_rp_johnson: assert property (@(posedge clk_i) disable iff (!rstn_i)
        johnson_valid(token_t'(rp_sync), BUFFER_DEPTH));

    a_not_full_and_empty: assert property (@(posedge clk_i) disable iff (!rstn_i)
        !(full && empty));

endmodule

// File: tb/tb_cdc_token_fifo_tx.sv
// Bench for cdc_token_fifo_tx: directed fill/free/reset scenarios plus a random producer against
// an asynchronous reference receiver, scored with a queue of expected beats.
module tb_cdc_token_fifo_tx;

    localparam int N  = 8;
    localparam int DW = 32;

    logic          clk;
    logic          rclk;
    logic          rstn;
    logic          valid;
    logic [DW-1:0] data;
    logic          ready;
    logic [N-1:0]  wt;
    logic [N-1:0]  rp_async;
    logic [DW-1:0] data_async;

    int            n_cmp;
    int            n_err;
    int            pushes;
    int            pops;
    logic [DW-1:0] exp_q [$];
    bit   [15:0]   seen;

    cdc_token_fifo_tx #(.DATA_WIDTH(DW), .BUFFER_DEPTH(N)) dut (
        .clk_i               (clk),
        .rstn_i              (rstn),
        .valid_i             (valid),
        .data_i              (data),
        .ready_o             (ready),
        .writetoken_o        (wt),
        .readpointer_async_i (rp_async),
        .data_async_o        (data_async)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial rclk = 1'b0;
    always #6 rclk = ~rclk;

    // Johnson code after k steps from zero: k ones filling from the LSB, then zeros from the LSB.
    function automatic logic [7:0] jcode(input int k);
        int         m;
        logic [7:0] ones;
        m    = k % 16;
        ones = 8'hFF;
        if (m <= 8) return 8'((1 << m) - 1);
        return ones << (m - 8);
    endfunction

    task automatic test_reset();
        rstn = 1'b0; valid = 1'b0; data = '0; rp_async = '0;
        #22;
        n_cmp++; if (wt !== 8'h00) begin n_err++; $display("FAIL reset_wt: got %h expected 00", wt); end
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", ready); end
        n_cmp++; if (data_async !== '0) begin n_err++; $display("FAIL reset_data: got %h expected 0", data_async); end
        @(negedge clk); rstn = 1'b1;
        #1;
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL release_ready0: got %b expected 0", ready); end
        @(posedge clk); #1;
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL release_ready1: got %b expected 1", ready); end
        pushes = 0; pops = 0; exp_q.delete();
    endtask

    task automatic test_fill();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            valid = 1'b1; data = 32'hA0 + 32'(i);
            n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL fill_ready[%0d]: got %b expected 1", i, ready); end
            @(posedge clk);
            exp_q.push_back(data); pushes++;
            #1;
            n_cmp++; if (wt !== jcode(pushes)) begin n_err++; $display("FAIL fill_wt[%0d]: got %h expected %h", i, wt, jcode(pushes)); end
        end
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b expected 0", ready); end
        @(negedge clk); data = 32'hDEADBEEF;
        @(posedge clk); #1;
        n_cmp++; if (wt !== 8'hFF) begin n_err++; $display("FAIL stall_wt: got %h expected ff", wt); end
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL stall_ready: got %b expected 0", ready); end
        valid = 1'b0;
        n_cmp++; if (data_async !== 32'hA0) begin n_err++; $display("FAIL stall_slot0: got %h expected a0", data_async); end
    endtask

    task automatic test_free_one();
        @(posedge clk); #2;
        rp_async = jcode(1);
        void'(exp_q.pop_front()); pops++;
        #1;
        n_cmp++; if (data_async !== 32'hA1) begin n_err++; $display("FAIL rp01_data: got %h expected a1", data_async); end
        @(posedge clk); #1;
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL free_ready_1st: got %b expected 0", ready); end
        @(posedge clk); #1;
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL free_ready_2nd: got %b expected 1", ready); end
        @(negedge clk); valid = 1'b1; data = 32'hB0;
        @(posedge clk);
        exp_q.push_back(data); pushes++;
        #1; valid = 1'b0;
        n_cmp++; if (wt !== 8'hFE) begin n_err++; $display("FAIL refill_wt: got %h expected fe", wt); end
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL refill_ready: got %b expected 0", ready); end
    endtask

    task automatic test_same_cycle();
        @(negedge clk); valid = 1'b1; data = 32'hC0;
        #1; rp_async = jcode(2);
        void'(exp_q.pop_front()); pops++;
        @(posedge clk); #1;
        n_cmp++; if (wt !== 8'hFE || ready !== 1'b0) begin n_err++; $display("FAIL same_cyc_p1: got wt=%h rdy=%b expected wt=fe rdy=0", wt, ready); end
        @(posedge clk); #1;
        n_cmp++; if (wt !== 8'hFE || ready !== 1'b1) begin n_err++; $display("FAIL same_cyc_p2: got wt=%h rdy=%b expected wt=fe rdy=1", wt, ready); end
        @(posedge clk);
        exp_q.push_back(data); pushes++;
        #1; valid = 1'b0;
        n_cmp++; if (wt !== 8'hFC || ready !== 1'b0) begin n_err++; $display("FAIL same_cyc_p3: got wt=%h rdy=%b expected wt=fc rdy=0", wt, ready); end
    endtask

    task automatic test_random();
        int            accepted;
        int            target;
        logic [N-1:0]  wt_s1;
        logic [N-1:0]  wt_s2;
        accepted = 0;
        target   = pushes + 1000;
        wt_s1    = wt;
        wt_s2    = wt;
        seen     = '0;
        fork
            begin : producer
                int   cyc;
                logic rdy;
                cyc = 0;
                while (accepted < 1000 && cyc < 20000) begin
                    @(negedge clk); cyc++;
                    valid = ($urandom_range(0, 99) < 70);
                    data  = $urandom;
                    rdy   = ready;
                    n_cmp++;
                    if (rdy && (pushes - pops) >= N) begin
                        n_err++; $display("FAIL rand_overflow: got ready=1 with occupancy %0d expected ready=0", pushes - pops);
                    end
                    @(posedge clk);
                    if (valid && rdy) begin
                        exp_q.push_back(data); pushes++; accepted++;
                    end
                    #1;
                    seen[pushes % 16] = 1'b1;
                    n_cmp++;
                    if (wt !== jcode(pushes)) begin
                        n_err++; $display("FAIL rand_wt: got %h expected %h", wt, jcode(pushes));
                    end
                end
                valid = 1'b0;
                n_cmp++;
                if (accepted != 1000) begin n_err++; $display("FAIL rand_accept_budget: got %0d expected 1000", accepted); end
            end
            begin : consumer
                int            rcyc;
                logic [DW-1:0] e;
                rcyc = 0;
                while (pops < target && rcyc < 20000) begin
                    @(posedge rclk); rcyc++;
                    wt_s2 = wt_s1;
                    wt_s1 = wt;
                    @(negedge rclk);
                    if (wt_s2 !== jcode(pops) && $urandom_range(0, 99) < 45) begin
                        n_cmp++;
                        if (exp_q.size() == 0) begin
                            n_err++; $display("FAIL rand_underflow: got beat %h expected none", data_async);
                        end else begin
                            e = exp_q.pop_front();
                            if (data_async !== e) begin n_err++; $display("FAIL rand_data: got %h expected %h", data_async, e); end
                        end
                        pops++;
                        rp_async = jcode(pops);
                    end
                end
                n_cmp++;
                if (pops != target) begin n_err++; $display("FAIL rand_drain_budget: got %0d expected %0d", pops, target); end
            end
        join
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rand_leftover: got %0d expected 0", exp_q.size()); end
        n_cmp++; if (seen !== 16'hFFFF) begin n_err++; $display("FAIL rand_codes: got %h expected ffff", seen); end
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL rand_empty_ready: got %b expected 1", ready); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); valid = 1'b1; data = $urandom;
            @(posedge clk);
        end
        #1; valid = 1'b0;
        n_cmp++; if (wt !== jcode(pushes + 3)) begin n_err++; $display("FAIL mid_queued_wt: got %h expected %h", wt, jcode(pushes + 3)); end
        @(posedge clk); #3;
        rstn = 1'b0; rp_async = '0;
        pushes = 0; pops = 0; exp_q.delete();
        #1;
        n_cmp++; if (wt !== 8'h00 || ready !== 1'b0) begin n_err++; $display("FAIL mid_reset: got wt=%h rdy=%b expected wt=00 rdy=0", wt, ready); end
        n_cmp++; if (data_async !== '0) begin n_err++; $display("FAIL mid_reset_data: got %h expected 0", data_async); end
        repeat (2) @(posedge clk);
        @(negedge clk); rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (wt !== 8'h00 || ready !== 1'b1) begin n_err++; $display("FAIL mid_after: got wt=%h rdy=%b expected wt=00 rdy=1", wt, ready); end
        @(negedge clk); valid = 1'b1; data = 32'hD0;
        @(posedge clk); #1; valid = 1'b0;
        n_cmp++; if (wt !== 8'h01) begin n_err++; $display("FAIL mid_push_wt: got %h expected 01", wt); end
        n_cmp++; if (data_async !== 32'hD0) begin n_err++; $display("FAIL mid_push_data: got %h expected d0", data_async); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_fill();
        test_free_one();
        test_same_cycle();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
